// File: rtl/booth_divider_seq.sv
// booth_divider_seq: sequential radix-2 restoring divider, one quotient bit per cycle
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   dividend     A, captured on accepted start
//   divisor      M, captured on accepted start
//   busy         high from accept until DONE is entered
//   valid        results valid, held until the next accepted start
//   quotient     A / M, truncated toward zero
//   remainder    A - q*M, sign follows the dividend
//   div_by_zero  set with valid when the divisor is zero
//
// Build option: define DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module booth_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, CAPT, ITER, FIX, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, m_q, m_d, qs_q, qs_d, quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH:0]   r_q, r_d, shifted;
    logic [WIDTH+1:0] trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
`ifdef DIV_SIGNED_EN
    logic             sa_q, sa_d, sm_q, sm_d;
`endif
    // Shift the next dividend bit into the partial remainder; the extra top bit
    // of the trial difference is its sign, so a clear bit means the divisor fits.
    assign shifted = {r_q[WIDTH-1:0], qs_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b0, m_q};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        qs_d    = qs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sm_d    = sm_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CAPT;
                    a_d     = dividend;
                    m_d     = divisor;
                    dz_d    = 1'b0;
                end
            end
            CAPT: begin
                r_d   = '0;
                cnt_d = '0;
`ifdef DIV_SIGNED_EN
                sa_d  = a_q[WIDTH-1];
                sm_d  = m_q[WIDTH-1];
                qs_d  = a_q[WIDTH-1] ? -a_q : a_q;
                m_d   = m_q[WIDTH-1] ? -m_q : m_q;
`else
                qs_d  = a_q;
`endif
                if (m_q == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = a_q;
                    dz_d    = 1'b1;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d   = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
                qs_d  = {qs_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : ITER;
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
                quo_d = (sa_q ^ sm_q) ? -qs_q : qs_q;
                rem_d = sa_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
`else
                quo_d = qs_q;
                rem_d = r_q[WIDTH-1:0];
`endif
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            qs_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            qs_q    <= qs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sm_q    <= sm_d;
`endif
        end
    end
    assign busy        = (state_q == CAPT) || (state_q == ITER) || (state_q == FIX);
    assign valid       = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
endmodule
